// File: rtl/icache_dm.sv
// Direct-mapped, blocking instruction cache; refills whole lines from the read bridge.
// All outputs are registered; hit/miss is resolved from the arrays when a request is accepted.
module icache_dm #(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 4,
  parameter int unsigned TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  localparam int unsigned WordBits = OFFSET_BITS - 2;
  localparam int unsigned Lines    = 2 ** INDEX_BITS;
  localparam int unsigned Words    = 2 ** WordBits;
  localparam int unsigned TagLsb   = OFFSET_BITS + INDEX_BITS;

  typedef enum logic [2:0] {StIdle, StLookup, StMiss, StRefill, StRespond} state_e;

  state_e              r_state;
  logic [Lines-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [Lines];
  logic [31:0]         r_data [Lines][Words];
  logic [31:0]         r_buf  [Words];
  logic [WordBits-1:0] r_cnt;
  logic [31:2]         r_req_addr;
  logic                r_hit;
  logic                r_addr_ok;
  logic                r_data_ok;
  logic                r_rd_req;
  logic [31:0]         r_rdata;
  logic [31:0]         r_rd_addr;

  logic                w_accept;
  logic [INDEX_BITS-1:0] w_new_idx;
  logic [INDEX_BITS-1:0] w_req_idx;
  logic [TAG_BITS-1:0] w_new_tag;
  logic [TAG_BITS-1:0] w_req_tag;
  logic [WordBits-1:0] w_new_off;
  logic [WordBits-1:0] w_req_off;
  logic                w_new_hit;
  logic                w_beat;
  logic                w_fill_done;
  logic [31:0]         w_line [Words];
  logic                w_unused_addr;

  assign w_accept      = inst_req & r_addr_ok;
  assign w_new_idx     = inst_addr[TagLsb-1:OFFSET_BITS];
  assign w_new_tag     = inst_addr[31:TagLsb];
  assign w_new_off     = inst_addr[OFFSET_BITS-1:2];
  assign w_req_idx     = r_req_addr[TagLsb-1:OFFSET_BITS];
  assign w_req_tag     = r_req_addr[31:TagLsb];
  assign w_req_off     = r_req_addr[OFFSET_BITS-1:2];
  assign w_new_hit     = r_valid[w_new_idx] && (r_tag[w_new_idx] == w_new_tag);
  assign w_beat        = (r_state == StRefill) && ret_valid;
  assign w_fill_done   = w_beat && ret_last;
  assign w_unused_addr = ^inst_addr[1:0];

  // Complete line as it will be written: buffered beats plus the beat arriving now.
  always_comb begin
    for (int k = 0; k < Words; k++) begin
      w_line[k] = (r_cnt == WordBits'(k)) ? ret_data : r_buf[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_valid    <= '0;
      r_cnt      <= '0;
      r_req_addr <= '0;
      r_hit      <= 1'b0;
      r_addr_ok  <= 1'b1;
      r_data_ok  <= 1'b0;
      r_rdata    <= '0;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_data_ok <= 1'b0;
      unique case (r_state)
        StIdle, StLookup: begin
          if (w_accept) begin
            r_req_addr <= inst_addr[31:2];
            r_hit      <= w_new_hit;
            r_data_ok  <= w_new_hit;
            r_addr_ok  <= w_new_hit;
            r_rdata    <= r_data[w_new_idx][w_new_off];
            r_state    <= StLookup;
          end else if (r_state == StIdle || r_hit) begin
            r_addr_ok <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_addr_ok <= 1'b0;
            r_rd_req  <= 1'b1;
            r_rd_addr <= {r_req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            r_state   <= StMiss;
          end
        end
        StMiss: begin
          if (rd_rdy) begin
            r_rd_req <= 1'b0;
            r_cnt    <= '0;
            r_state  <= StRefill;
          end
        end
        StRefill: begin
          if (ret_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (ret_last) begin
              r_valid[w_req_idx] <= 1'b1;
              r_data_ok          <= 1'b1;
              r_rdata            <= w_line[w_req_off];
              r_state            <= StRespond;
            end
          end
        end
        StRespond: begin
          r_addr_ok <= 1'b1;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Data storage: a reset mid-refill simply never commits the buffered line.
  always_ff @(posedge clk) begin
    if (!reset && w_beat) begin
      r_buf[r_cnt] <= ret_data;
    end
    if (!reset && w_fill_done) begin
      r_tag[w_req_idx] <= w_req_tag;
      for (int k = 0; k < Words; k++) begin
        r_data[w_req_idx][k] <= w_line[k];
      end
    end
  end

  assign inst_addr_ok = r_addr_ok;
  assign inst_data_ok = r_data_ok;
  assign inst_rdata   = r_rdata;
  assign rd_req       = r_rd_req;
  assign rd_type      = 3'b100;
  assign rd_addr      = r_rd_addr;

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: transaction-level cache model checked every cycle,
// plus directed scenarios with hand-computed data and latency expectations.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy = 1'b0;
  logic        ret_valid = 1'b0;
  logic        ret_last = 1'b0;
  logic [31:0] ret_data = '0;

  icache_dm dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .rd_req       (rd_req),
    .rd_type      (rd_type),
    .rd_addr      (rd_addr),
    .rd_rdy       (rd_rdy),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: line address and words per index; one outstanding miss at a time.
  logic [31:0] m_line_addr [int];
  logic [31:0] m_word [int];
  logic [31:0] m_buf [4];
  bit          miss_active = 0;
  bit          hs_done = 0;
  bit          beats_done = 0;
  int          miss_acc_cyc = 0;
  int          hs_cyc = 0;
  int          beat_n = 0;
  logic [31:0] miss_addr = '0;
  int          exp_dok_cyc = -1;
  logic [31:0] exp_data = '0;

  // Observations of the DUT, for the directed literal checks.
  int          dok_cyc_q [$];
  logic [31:0] dok_dat_q [$];
  int          rise_n = 0;
  int          rise_cyc = 0;
  logic [31:0] rise_addr = '0;
  logic        prev_rd_req = 1'b0;

  always @(negedge clk) begin : model
    logic exp_aok, exp_rreq, exp_dok;
    int idx;
    if (reset) begin
      miss_active = 0;
      exp_dok_cyc = -1;
      m_line_addr.delete();
      m_word.delete();
      prev_rd_req = 1'b0;
    end else begin
      exp_aok  = !(miss_active && cyc > miss_acc_cyc);
      exp_rreq = miss_active && !hs_done && (cyc >= miss_acc_cyc + 2);
      exp_dok  = (cyc == exp_dok_cyc);
      check("addr_ok", inst_addr_ok, exp_aok);
      check("data_ok", inst_data_ok, exp_dok);
      if (exp_dok) check("rdata", inst_rdata, exp_data);
      check("rd_req", rd_req, exp_rreq);
      if (exp_rreq) check("rd_addr", rd_addr, {miss_addr[31:4], 4'b0});
      check("rd_type", rd_type, 3'b100);

      if (inst_data_ok) begin
        dok_cyc_q.push_back(cyc);
        dok_dat_q.push_back(inst_rdata);
      end
      if (rd_req && !prev_rd_req) begin
        rise_n++;
        rise_cyc  = cyc;
        rise_addr = rd_addr;
      end
      prev_rd_req = rd_req;

      if (miss_active && beats_done && exp_dok) miss_active = 0;
      if (exp_rreq && rd_rdy) begin
        hs_done = 1;
        hs_cyc  = cyc;
      end
      if (miss_active && hs_done && !beats_done && cyc > hs_cyc && ret_valid) begin
        m_buf[beat_n & 3] = ret_data;
        beat_n++;
        if (ret_last) begin
          idx = int'(miss_addr[9:4]);
          m_line_addr[idx] = {miss_addr[31:4], 4'b0};
          for (int w = 0; w < 4; w++) m_word[idx * 4 + w] = m_buf[w];
          exp_data    = m_buf[miss_addr[3:2]];
          exp_dok_cyc = cyc + 1;
          beats_done  = 1;
        end
      end
      if (inst_req && exp_aok) begin
        idx = int'(inst_addr[9:4]);
        if (m_line_addr.exists(idx) && m_line_addr[idx] == {inst_addr[31:4], 4'b0}) begin
          exp_dok_cyc = cyc + 1;
          exp_data    = m_word[idx * 4 + int'(inst_addr[3:2])];
        end else begin
          miss_active  = 1;
          miss_acc_cyc = cyc;
          miss_addr    = inst_addr;
          hs_done      = 0;
          beats_done   = 0;
          beat_n       = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, output int t);
    int n = 0;
    inst_req  = 1'b1;
    inst_addr = addr;
    while (!inst_addr_ok && n < 64) begin
      tick();
      n++;
    end
    if (n == 64) begin
      n_checks++;
      n_errors++;
      $display("FAIL fetch_timeout: addr_ok never seen for 0x%08h", addr);
    end
    t = cyc;
    tick();
    inst_req = 1'b0;
  endtask

  task automatic refill(input logic [127:0] line, input int dly, input int gap, input int nbeats);
    int n = 0;
    while (!rd_req && n < 64) begin
      tick();
      n++;
    end
    if (n == 64) begin
      n_checks++;
      n_errors++;
      $display("FAIL refill_timeout: rd_req never seen, got %0d expected 1", rd_req);
    end
    repeat (dly) tick();
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      ret_valid = 1'b1;
      ret_data  = line[32*i +: 32];
      ret_last  = (i == 3);
      tick();
      ret_valid = 1'b0;
      ret_last  = 1'b0;
      if (i < 3) repeat (gap) tick();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int t;
    int n0;
    int r0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_addr_ok", inst_addr_ok, 1);
    check("rst_data_ok", inst_data_ok, 0);
    check("rst_rdata", inst_rdata, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    tick();

    // Cold miss
    n0 = dok_cyc_q.size();
    fetch(32'hbfc00000, t);
    refill({32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 4);
    repeat (2) tick();
    check("cold_rdreq_lat", rise_cyc - t, 2);
    check("cold_rd_addr", rise_addr, 32'hbfc00000);
    check("cold_dok_count", dok_cyc_q.size(), n0 + 1);
    check("cold_dok_lat", dok_cyc_q[n0] - t, 7);
    check("cold_data", dok_dat_q[n0], 32'h11);

    // Back-to-back hits
    n0 = dok_cyc_q.size();
    r0 = rise_n;
    inst_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_addr = 32'hbfc00004 + 4 * i;
      check("burst_addr_ok", inst_addr_ok, 1);
      if (i == 0) t = cyc;
      tick();
    end
    inst_req = 1'b0;
    repeat (2) tick();
    check("burst_dok_count", dok_cyc_q.size(), n0 + 3);
    for (int i = 0; i < 3; i++) begin
      check("burst_dok_cyc", dok_cyc_q[n0 + i] - t, 1 + i);
      check("burst_data", dok_dat_q[n0 + i], 32'h22 + 32'h11 * i);
    end
    check("burst_no_rdreq", rise_n, r0);

    // Conflict on index 0, then the original line misses again
    n0 = dok_cyc_q.size();
    fetch(32'hbfc00400, t);
    refill({32'ha4, 32'ha3, 32'ha2, 32'ha1}, 0, 0, 4);
    repeat (2) tick();
    check("conf_rd_addr", rise_addr, 32'hbfc00400);
    check("conf_data", dok_dat_q[n0], 32'ha1);
    r0 = rise_n;
    n0 = dok_cyc_q.size();
    fetch(32'hbfc00000, t);
    refill({32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 4);
    repeat (2) tick();
    check("conf_remiss", rise_n, r0 + 1);
    check("conf_re_data", dok_dat_q[n0], 32'h11);

    // Bridge stalls: rd_rdy late, two-cycle gaps between beats
    n0 = dok_cyc_q.size();
    fetch(32'h00001008, t);
    refill({32'hb3, 32'hb2, 32'hb1, 32'hb0}, 3, 2, 4);
    repeat (3) tick();
    check("stall_rd_addr", rise_addr, 32'h00001000);
    check("stall_dok_count", dok_cyc_q.size(), n0 + 1);
    check("stall_dok_lat", dok_cyc_q[n0] - t, 16);
    check("stall_data", dok_dat_q[n0], 32'hb2);

    // Reset after two beats aborts the refill
    n0 = dok_cyc_q.size();
    fetch(32'h00002014, t);
    refill({32'hc3, 32'hc2, 32'hc1, 32'hc0}, 0, 0, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_addr_ok", inst_addr_ok, 1);
    check("midrst_data_ok", inst_data_ok, 0);
    tick();
    check("midrst_no_dok", dok_cyc_q.size(), n0);
    r0 = rise_n;
    fetch(32'h00002014, t);
    refill({32'hc3, 32'hc2, 32'hc1, 32'hc0}, 0, 0, 4);
    repeat (2) tick();
    check("midrst_remiss", rise_n, r0 + 1);
    check("midrst_data", dok_dat_q[n0], 32'hc1);

    // Stray beats in IDLE and LOOKUP must not disturb the arrays
    r0 = rise_n;
    ret_valid = 1'b1;
    ret_last  = 1'b1;
    ret_data  = 32'hdeadbeef;
    tick();
    n0 = dok_cyc_q.size();
    fetch(32'h00002018, t);
    tick();
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    tick();
    check("stray_data", dok_dat_q[n0], 32'hc2);
    fetch(32'h00002014, t);
    repeat (2) tick();
    check("stray_orig_data", dok_dat_q[n0 + 1], 32'hc1);
    check("stray_no_rdreq", rise_n, r0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
